serial_accumulator_pipeline_floating_point32: RTL and testbench

- Reduces each group of NUM_INPUT serially arriving IEEE-754 single-precision values to one fp32 sum, using a single pipelined fp32 adder of latency ADD_LAT.
- Parametrised successor to the fixed 32-input serial adder.
- Adds a configurable group length and adder latency, input backpressure (o_ready) and back-to-back group processing.
- Sits between a layer's product stream and the activation stage of a DQN neuron.

---
 rtl/serial_accumulator_pipeline_floating_point32.sv | 230 +++++++++++++++++++++++
 tb/tb_serial_accumulator_pipeline_floating_point32.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_accumulator_pipeline_floating_point32.sv
// -----------------------------------------------------------------------------
// serial_accumulator_pipeline_floating_point32
//
// Reduces each group of NUM_INPUT serially arriving IEEE-754 fp32 values to a
// single fp32 sum. One pipelined fp32 adder (latency ADD_LAT) is shared by
// ADD_LAT interleaved partial-sum slots. After the last input the slots are
// drained and then folded serially into one result.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   i_valid  - i_data valid; accepted when i_valid && o_ready
//   i_data   - fp32 operand
//   o_ready  - block accepts input this cycle (ACCUM state)
//   o_data   - fp32 group sum, held until the next result
//   o_valid  - single-cycle pulse marking a new o_data
// -----------------------------------------------------------------------------
module serial_accumulator_pipeline_floating_point32 #(
    parameter int NUM_INPUT = 32,
    parameter int ADD_LAT   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_data,
    output logic        o_ready,
    output logic [31:0] o_data,
    output logic        o_valid
);

    localparam int CW = $clog2(NUM_INPUT) + 1;
    localparam int SW = $clog2(ADD_LAT);
    localparam int FW = SW + 1;

    typedef enum logic [1:0] {ACCUM, DRAIN, FOLD} state_e;

    // fp32 add, round-to-nearest-even, subnormals supported, NaN/Inf handled.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, res;
        logic [7:0]  ex, ey;
        logic [26:0] mx, my, sh;
        logic [27:0] s;
        logic [9:0]  e, d;
        logic [24:0] r;
        logic        rnd, sgn;
        // x always holds the operand of larger magnitude
        if (a[30:0] >= b[30:0]) begin x = a; y = b; end
        else                    begin x = b; y = a; end
        ex  = x[30:23];
        ey  = y[30:23];
        res = 32'h0;
        if (ex == 8'hFF || ey == 8'hFF) begin
            if ((ex == 8'hFF && |x[22:0]) || (ey == 8'hFF && |y[22:0]) ||
                (ey == 8'hFF && x[31] != y[31]))
                res = 32'h7FC0_0000;
            else
                res = x;
        end else begin
            // 24-bit significands plus guard/round/sticky; subnormals use exponent 1
            mx = {(ex != 8'd0), x[22:0], 3'b000};
            my = {(ey != 8'd0), y[22:0], 3'b000};
            if (ex == 8'd0) ex = 8'd1;
            if (ey == 8'd0) ey = 8'd1;
            d = {2'b00, ex} - {2'b00, ey};
            if (d > 10'd26) begin
                sh = {26'd0, |my};
            end else begin
                sh = my >> d;
                if ((sh << d) != my) sh[0] = 1'b1;
            end
            e = {2'b00, ex};
            if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, sh};
            else                s = {1'b0, mx} - {1'b0, sh};
            // exact cancellation yields +0 under round-to-nearest
            sgn = (s == 28'd0 && x[31] != y[31]) ? 1'b0 : x[31];
            if (s[27]) begin
                s = {1'b0, s[27:1]} | {27'd0, s[0]};
                e = e + 10'd1;
            end
            for (int i = 0; i < 26; i++) begin
                if (!s[26] && e > 10'd1) begin
                    s = s << 1;
                    e = e - 10'd1;
                end
            end
            rnd = s[2] && (s[1] || s[0] || s[3]);
            r   = {1'b0, s[26:3]} + {24'd0, rnd};
            if (r[24]) begin
                r = {1'b0, r[24:1]};
                e = e + 10'd1;
            end
            if (e >= 10'd255) res = {sgn, 8'hFF, 23'd0};
            else              res = {sgn, (r[23] ? e[7:0] : 8'd0), r[22:0]};
        end
        return res;
    endfunction

    state_e          state_q, state_d;
    logic [CW-1:0]   in_cnt_q, in_cnt_d;
    logic [SW-1:0]   slot_idx_q, slot_idx_d;
    logic [FW-1:0]   fold_idx_q, fold_idx_d;
    logic [31:0]     slot_q [ADD_LAT];
    logic [31:0]     slot_d [ADD_LAT];
    logic [31:0]     o_data_q, o_data_d;
    logic            o_valid_q, o_valid_d;

    // Adder pipeline: data plus tags saying where the result goes
    logic [31:0]        pipe_data_q [ADD_LAT];
    logic               pipe_fold_q [ADD_LAT];
    logic [SW-1:0]      pipe_slot_q [ADD_LAT];
    logic [ADD_LAT-1:0] pipe_vld_q;

    logic          iss_vld, iss_fold;
    logic [SW-1:0] iss_slot;
    logic [31:0]   iss_a, iss_b;

    logic          out_vld, out_fold;
    logic [SW-1:0] out_slot;
    logic [31:0]   out_data;

    assign out_vld  = pipe_vld_q[ADD_LAT-1];
    assign out_fold = pipe_fold_q[ADD_LAT-1];
    assign out_slot = pipe_slot_q[ADD_LAT-1];
    assign out_data = pipe_data_q[ADD_LAT-1];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        slot_idx_d = slot_idx_q;
        fold_idx_d = fold_idx_q;
        slot_d     = slot_q;
        o_data_d   = o_data_q;
        o_valid_d  = 1'b0;
        iss_vld    = 1'b0;
        iss_fold   = 1'b0;
        iss_slot   = '0;
        iss_a      = 32'h0;
        iss_b      = 32'h0;

        if (out_vld && !out_fold) slot_d[out_slot] = out_data;

        case (state_q)
            ACCUM: begin
                if (i_valid) begin
                    iss_vld  = 1'b1;
                    iss_slot = slot_idx_q;
                    // a write-back landing in this same cycle is newer than the slot register
                    iss_a    = (out_vld && !out_fold && out_slot == slot_idx_q) ?
                               out_data : slot_q[slot_idx_q];
                    iss_b    = i_data;
                    if (in_cnt_q == CW'(NUM_INPUT - 1)) begin
                        in_cnt_d   = '0;
                        slot_idx_d = '0;
                        state_d    = DRAIN;
                    end else begin
                        in_cnt_d   = in_cnt_q + CW'(1);
                        slot_idx_d = (slot_idx_q == SW'(ADD_LAT - 1)) ? '0 : slot_idx_q + SW'(1);
                    end
                end
            end
            DRAIN: begin
                if (pipe_vld_q == '0) begin
                    iss_vld    = 1'b1;
                    iss_fold   = 1'b1;
                    iss_a      = slot_q[0];
                    iss_b      = slot_q[1];
                    fold_idx_d = FW'(2);
                    state_d    = FOLD;
                end
            end
            FOLD: begin
                if (out_vld) begin
                    if (fold_idx_q == FW'(ADD_LAT)) begin
                        o_data_d  = out_data;
                        o_valid_d = 1'b1;
                        for (int i = 0; i < ADD_LAT; i++) slot_d[i] = 32'h0;
                        state_d   = ACCUM;
                    end else begin
                        iss_vld    = 1'b1;
                        iss_fold   = 1'b1;
                        iss_a      = out_data;
                        iss_b      = slot_q[fold_idx_q[SW-1:0]];
                        fold_idx_d = fold_idx_q + FW'(1);
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            in_cnt_q   <= '0;
            slot_idx_q <= '0;
            fold_idx_q <= '0;
            o_data_q   <= 32'h0;
            o_valid_q  <= 1'b0;
            pipe_vld_q <= '0;
            for (int i = 0; i < ADD_LAT; i++) slot_q[i] <= 32'h0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            slot_idx_q <= slot_idx_d;
            fold_idx_q <= fold_idx_d;
            o_data_q   <= o_data_d;
            o_valid_q  <= o_valid_d;
            pipe_vld_q <= {pipe_vld_q[ADD_LAT-2:0], iss_vld};
            slot_q     <= slot_d;
        end
    end

    // NOTE: pipeline payload has no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        pipe_data_q[0] <= fp_add(iss_a, iss_b);
        pipe_fold_q[0] <= iss_fold;
        pipe_slot_q[0] <= iss_slot;
        for (int i = 1; i < ADD_LAT; i++) begin
            pipe_data_q[i] <= pipe_data_q[i-1];
            pipe_fold_q[i] <= pipe_fold_q[i-1];
            pipe_slot_q[i] <= pipe_slot_q[i-1];
        end
    end

    assign o_ready = (state_q == ACCUM);
    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;

endmodule

// File: tb/tb_serial_accumulator_pipeline_floating_point32.sv
// -----------------------------------------------------------------------------
// Directed testbench for serial_accumulator_pipeline_floating_point32.
// dut  : default parameters (NUM_INPUT=32, ADD_LAT=4)
// dut3 : NUM_INPUT=3, ADD_LAT=4
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Event times are expressed as the rising-edge index at
// which the event is seen by the design or its consumer.
// -----------------------------------------------------------------------------
module tb_serial_accumulator_pipeline_floating_point32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        i_valid, o_ready, o_valid;
    logic [31:0] i_data, o_data;
    logic        i_valid_3, o_ready_3, o_valid_3;
    logic [31:0] i_data_3, o_data_3;

    serial_accumulator_pipeline_floating_point32 dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid)
    );

    serial_accumulator_pipeline_floating_point32 #(.NUM_INPUT(3), .ADD_LAT(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid_3), .i_data(i_data_3),
        .o_ready(o_ready_3), .o_data(o_data_3), .o_valid(o_valid_3)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Result log filled by the monitor
    logic [31:0] res_q[$];
    int          edge_q[$];
    logic [31:0] res3_q[$];
    int          edge3_q[$];
    int          pulse_cnt = 0;

    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            res_q.push_back(o_data);
            edge_q.push_back(cyc + 1);
            pulse_cnt++;
        end
        if (o_valid_3 === 1'b1) begin
            res3_q.push_back(o_data_3);
            edge3_q.push_back(cyc + 1);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Positive fp32 encoding of q/4 (stimulus helper, q in 1..2^22)
    function automatic logic [31:0] fp_q(input int q);
        logic [31:0] u, m;
        int          p;
        u = q;
        p = 0;
        for (int i = 0; i < 32; i++) if (u[i]) p = i;
        m = u << (23 - p);
        return {1'b0, 8'(p + 125), m[22:0]};
    endfunction

    // Holds i_valid until accepted; returns the acceptance edge index
    task automatic send(input bit to3, input logic [31:0] d, output int acc_edge);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        if (to3) begin i_valid_3 = 1'b1; i_data_3 = d; end
        else     begin i_valid   = 1'b1; i_data   = d; end
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = to3 ? o_ready_3 : o_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (to3) i_valid_3 = 1'b0;
        else     i_valid   = 1'b0;
        acc_edge = acc ? cyc : -1;
        if (!acc) check("accept timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic get_result(input bit from3, output logic [31:0] d, output int e);
        int n;
        n = 0;
        while (((from3 ? res3_q.size() : res_q.size()) == 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n > 0) #1;
        if ((from3 ? res3_q.size() : res_q.size()) == 0) begin
            d = 'x;
            e = -1000;
        end else if (from3) begin
            d = res3_q.pop_front();
            e = edge3_q.pop_front();
        end else begin
            d = res_q.pop_front();
            e = edge_q.pop_front();
        end
    endtask

    task automatic send_ones(output int last);
        for (int i = 0; i < 32; i++) send(1'b0, 32'h3F80_0000, last);
    endtask

    initial begin
        logic [31:0] d;
        int e, last, first2, busy_ready, cnt_before;
        bit seen;

        rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_valid_3 = 1'b0; i_data_3 = '0;
        #12;
        check("reset o_ready", 32'(o_ready), 32'd1);
        check("reset o_valid", 32'(o_valid), 32'd0);
        check("reset o_data", o_data, 32'h0);
        check("reset dut3 o_ready", 32'(o_ready_3), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 1) 32 x 1.0 back to back
        send_ones(last);
        busy_ready = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
            else if (o_ready) busy_ready++;
        end
        check("t1 o_ready low while busy", 32'(busy_ready), 32'd0);
        check("t1 o_ready in pulse cycle", 32'(o_ready), 32'd1);
        @(negedge clk);
        check("t1 o_valid single cycle", 32'(o_valid), 32'd0);
        check("t1 o_data held", o_data, 32'h4200_0000);
        @(posedge clk); #1;
        get_result(1'b0, d, e);
        check("t1 sum 32x1.0", d, 32'h4200_0000);
        check("t1 latency", 32'(e - last), 32'd18);

        // 2) 1.0 .. 32.0 with random gaps
        for (int n = 1; n <= 32; n++) begin
            send(1'b0, fp_q(4 * n), last);
            idle(int'($urandom_range(0, 3)));
        end
        get_result(1'b0, d, e);
        check("t2 sum 1..32 gaps", d, 32'h4404_0000);
        check("t2 latency", 32'(e - last), 32'd18);

        // 3) +x,-x pairs then an immediate group of 2.0
        for (int k = 0; k < 16; k++) begin
            send(1'b0, fp_q(14 + 15 * k), last);
            send(1'b0, fp_q(14 + 15 * k) | 32'h8000_0000, last);
        end
        first2 = 0;
        for (int i = 0; i < 32; i++) begin
            send(1'b0, 32'h4000_0000, e);
            if (i == 0) first2 = e;
        end
        get_result(1'b0, d, e);
        check("t3 cancel pairs", d, 32'h0000_0000);
        check("t3 latency", 32'(e - last), 32'd18);
        check("t3 accept in o_valid cycle", 32'(first2), 32'(e));
        get_result(1'b0, d, e);
        check("t3 sum 32x2.0", d, 32'h4280_0000);

        // 4) NUM_INPUT=3 on dut3
        send(1'b1, 32'h3F80_0000, last);
        send(1'b1, 32'h4000_0000, last);
        send(1'b1, 32'h4040_0000, last);
        get_result(1'b1, d, e);
        check("t4 dut3 sum 1+2+3", d, 32'h40C0_0000);
        check("t4 dut3 latency", 32'(e - last), 32'd18);

        // 5) +Inf offered while busy must be ignored
        send_ones(last);
        i_valid = 1'b1;
        i_data  = 32'h7F80_0000;
        repeat (10) @(posedge clk);
        #1;
        i_valid = 1'b0;
        get_result(1'b0, d, e);
        check("t5 sum with blocked inf", d, 32'h4200_0000);
        send_ones(last);
        get_result(1'b0, d, e);
        check("t5 next group sum", d, 32'h4200_0000);

        // 6) reset after 10 accepted inputs
        for (int i = 0; i < 10; i++) send(1'b0, 32'h3F80_0000, last);
        cnt_before = pulse_cnt;
        @(negedge clk); rst_n = 1'b0;
        #2;
        check("t6 reset o_ready", 32'(o_ready), 32'd1);
        check("t6 reset o_valid", 32'(o_valid), 32'd0);
        check("t6 reset o_data", o_data, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        idle(30);
        check("t6 no pulse for aborted group", 32'(pulse_cnt), 32'(cnt_before));
        send_ones(last);
        get_result(1'b0, d, e);
        check("t6 sum after reset", d, 32'h4200_0000);
        check("t6 latency", 32'(e - last), 32'd18);

        idle(5);
        check("no stray results", 32'(res_q.size() + res3_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
